// File: rtl/lane_pkg.sv
// Shared types and sizing helpers for the candidate-point lane.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lane_pkg;

    // Sequencer states of the shared dedup engine arbiter.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } arb_state_t;

    // Width of one x position: enough for 0..img_width plus a spare bit,
    // matching the engine's point format.
    function automatic int point_w(input int img_width);
        return $clog2(img_width) + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or above ptr, with wrap.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is honoured.
//
// Ports:
//   req       - request vector, one bit per requester
//   ptr       - index that has highest priority this cycle
//   grant     - one-hot grant (all zero when no request)
//   grant_idx - binary index of the granted requester (0 when none)
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic           found;
    logic [IDX_W:0] sum;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // ptr + k, reduced modulo NUM_REQ; the sum stays below 2*NUM_REQ
            // so one conditional subtract is enough for any NUM_REQ.
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/dedup_arbiter.sv
// Shares one remove_close_duplicates engine among NUM_REQ point producers.
// Latency: handshake N -> eng_start N+1 -> rsp_valid N+2+ENGINE_LATENCY.
// Backpressure: one job in flight; req_ready stays 0 until the response is taken.
//
// Ports:
//   clk, rst_n                   - clock, asynchronous active-low reset
//   req_valid/req_ready          - per-requester handshake, ready is a one-hot grant
//   req_points/req_importance    - candidate set of each requester
//   eng_start                    - one-cycle start pulse to the engine
//   eng_in_array/eng_importance  - held job inputs to the engine
//   eng_out_array                - engine result, valid ENGINE_LATENCY cycles after start
//   rsp_valid/rsp_ready          - response handshake
//   rsp_id/rsp_points            - requester index and filtered points
//   busy                         - a job is in progress
module dedup_arbiter
    import lane_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int IMG_WIDTH      = 416,
    parameter  int MAX_POINTS     = 5,
    parameter  int ENGINE_LATENCY = 40,
    localparam int W              = point_w(IMG_WIDTH),
    localparam int IDX_W          = $clog2(NUM_REQ),
    localparam int TMR_W          = $clog2(ENGINE_LATENCY)
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_REQ-1:0]                       req_valid,
    output logic [NUM_REQ-1:0]                       req_ready,
    input  logic [NUM_REQ-1:0][MAX_POINTS-1:0][W-1:0] req_points,
    input  logic [NUM_REQ-1:0][MAX_POINTS-1:0][W-1:0] req_importance,
    output logic                                     eng_start,
    output logic [MAX_POINTS-1:0][W-1:0]             eng_in_array,
    output logic [MAX_POINTS-1:0][W-1:0]             eng_importance,
    input  logic [MAX_POINTS-1:0][W-1:0]             eng_out_array,
    output logic                                     rsp_valid,
    input  logic                                     rsp_ready,
    output logic [IDX_W-1:0]                         rsp_id,
    output logic [MAX_POINTS-1:0][W-1:0]             rsp_points,
    output logic                                     busy
);

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rr_ptr_nxt;
    logic [TMR_W-1:0]   timer;
    logic [IDX_W-1:0]   hold_id;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               req_hs;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grant is only offered while idle, so a waiting requester sees ready=0
    // for the whole job and simply holds its valid.
    assign req_ready = (state == IDLE) ? grant : '0;
    assign req_hs    = |(req_valid & req_ready);

    assign rr_ptr_nxt = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                           : grant_idx + IDX_W'(1);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req_hs)        state_nxt = START;
            START:                      state_nxt = WAIT;
            WAIT:    if (timer == '0)   state_nxt = RESPOND;
            RESPOND: if (rsp_ready)     state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            timer          <= '0;
            hold_id        <= '0;
            eng_start      <= 1'b0;
            eng_in_array   <= '0;
            eng_importance <= '0;
            rsp_valid      <= 1'b0;
            rsp_id         <= '0;
            rsp_points     <= '0;
            busy           <= 1'b0;
        end else begin
            state <= state_nxt;

            // Status outputs are registered copies of the next state so they
            // line up exactly with the state they describe.
            eng_start <= (state_nxt == START);
            rsp_valid <= (state_nxt == RESPOND);
            busy      <= (state_nxt != IDLE);

            // Holding registers feed the engine directly; they only move on a
            // request handshake, so the engine sees a stable job throughout.
            if (req_hs) begin
                eng_in_array   <= req_points[grant_idx];
                eng_importance <= req_importance[grant_idx];
                hold_id        <= grant_idx;
                rr_ptr         <= rr_ptr_nxt;
            end

            // The engine has no done flag: count ENGINE_LATENCY cycles from
            // the start pulse and sample its output on the last one.
            if (state == START) begin
                timer <= TMR_W'(ENGINE_LATENCY - 1);
            end else if (state == WAIT && timer != '0) begin
                timer <= timer - TMR_W'(1);
            end

            if (state == WAIT && timer == '0) begin
                rsp_points <= eng_out_array;
                rsp_id     <= hold_id;
            end
        end
    end

endmodule

// File: doc/dedup_arbiter.md
# dedup_arbiter

Round-robin arbiter and sequencer that shares one `remove_close_duplicates` engine among `NUM_REQ` candidate-point producers, for example per-band sliding-window peak finders.
- Accepts one candidate set per handshake and holds it stable on the engine inputs for the whole job.
- Pulses the engine start and times completion with a fixed-latency counter, because the engine has no done flag.
- Returns the filtered points, tagged with the requester ID, over a valid/ready response port.

## Interface
- `NUM_REQ`, 4, number of requesters (≥2)
- `IMG_WIDTH`, 416, image width; point width `W = $clog2(IMG_WIDTH)+1` (10 at default)
- `MAX_POINTS`, 5, points per candidate set
- `ENGINE_LATENCY`, 40, cycles from `eng_start` until `eng_out_array` is final (≥2)
- `clk` in 1, clock
- `rst_n` in 1, reset, asynchronous, active-low
- `req_valid` in `[NUM_REQ]`, requester has a set pending
- `req_ready` out `[NUM_REQ]`, one-hot grant; handshake completes on `req_valid[i] && req_ready[i]`
- `req_points` in `[NUM_REQ][MAX_POINTS]`×W, candidate x positions
- `req_importance` in `[NUM_REQ][MAX_POINTS]`×W, candidate weights
- `eng_start` out 1, one-cycle engine start pulse
- `eng_in_array` out `[MAX_POINTS]`×W, held set
- `eng_importance` out `[MAX_POINTS]`×W, held weights
- `eng_out_array` in `[MAX_POINTS]`×W, engine result
- `rsp_valid` out 1, response available
- `rsp_ready` in 1, consumer accepts
- `rsp_id` out `$clog2(NUM_REQ)`, requester index of the response
- `rsp_points` out `[MAX_POINTS]`×W, filtered points (0 = removed)
- `busy` out 1, high in every state except IDLE

## Operation
- FSM states: IDLE, START, WAIT, RESPOND.
- IDLE:
  - Grant is combinational: the first `i` with `req_valid[i]` high, searching upward from `rr_ptr` with wrap.
  - `req_ready[i]` is 1 only in IDLE and only for the granted index.
  - On handshake: latch the points, importance and ID into the holding registers, set `rr_ptr` to granted index + 1 (mod `NUM_REQ`), and go to START.
  - With no `req_valid` high, stay in IDLE with all `req_ready` at 0.
- START: `eng_start`=1 for exactly this cycle; load the timer with `ENGINE_LATENCY-1`; go to WAIT.
- WAIT:
  - The timer decrements each cycle.
  - When the timer is 0, latch `eng_out_array` into `rsp_points` and go to RESPOND.
- RESPOND:
  - `rsp_valid`=1; `rsp_id` and `rsp_points` are held stable.
  - On `rsp_ready`, clear `rsp_valid` and go to IDLE.
- Engine inputs come from the holding registers. They change only on a request handshake, so they are stable from START through the end of RESPOND.
- `req_valid` deasserting after its handshake has no effect on the job.
- A request is never dropped. Requests arriving while `busy` wait, with `req_ready` at 0.

## Timing
- All outputs except `req_ready` are registered.
- Reset values: state IDLE, `rr_ptr`=0, timer 0, `eng_start`=0, `eng_in_array`/`eng_importance`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_points`=0, `busy`=0.
- Request handshake in cycle N:
  - `eng_start` high in N+1.
  - `eng_out_array` sampled at the end of cycle N+1+`ENGINE_LATENCY`.
  - `rsp_valid` high from N+2+`ENGINE_LATENCY`.
- Response handshake in cycle M: next request accept no earlier than M+1. Minimum job period is `ENGINE_LATENCY`+3 cycles.
- Simultaneous `req_valid` high: the grant follows round-robin order from `rr_ptr`, so there is no starvation. A continuously requesting requester waits at most `NUM_REQ`-1 jobs.
- `rsp_ready` held low: stay in RESPOND indefinitely, with outputs frozen and no new grant.
- `rsp_ready` high on the first RESPOND cycle: one-cycle `rsp_valid`.
- Reset mid-job (any state): return to reset values immediately. A partial result is never emitted. The engine is reset by the same `rst_n`.
- `rsp_points` are passed through unmodified; no arithmetic on point values.

## Structure
- Shared package `lane_pkg`:
  - `arb_state_t` enum (IDLE, START, WAIT, RESPOND).
  - Point-width constant/function `point_w(IMG_WIDTH)`.
- Sub-module `rr_arbiter`: parameter `NUM_REQ`; inputs `req`, `ptr`; outputs one-hot `grant` and `grant_idx`; combinational.
- Timer: inline down-counter of width `$clog2(ENGINE_LATENCY)`.

## Test plan
The bench uses an engine stub that drives `eng_out_array` = input with element 1 zeroed, `ENGINE_LATENCY` cycles after `eng_start`.
- Single request: `req_valid[2]` at cycle 10 with points {40,60,200,300,400} -> `req_ready[2]` at 10, `eng_start` at 11 only, `rsp_valid` at 52 with `rsp_id`=2 and `rsp_points` {40,0,200,300,400}.
- Round-robin: after reset, all four `req_valid` held high -> grant order 0,1,2,3,0,1 and job starts spaced 43 cycles apart with `rsp_ready`=1.
- Backpressure: `rsp_ready`=0 for 20 cycles after `rsp_valid` -> response fields frozen, `req_ready` all 0, `busy`=1; accept 1 cycle after `rsp_ready` rises.
- Input stability: change `req_points[1]` every cycle after its handshake -> `eng_in_array` constant from START to the response handshake.
- Reset mid-WAIT at cycle 30 of a job -> all outputs at reset values next cycle, no `rsp_valid`; post-reset grant starts from requester 0.
- Sparse/late requests: `req_valid[3]` pulsed only while `busy` -> held until IDLE, then granted; `req_valid`=0 everywhere -> FSM stays IDLE, `eng_start` never pulses.
